// File: rtl/fifo_arb_ctrl.sv
// Round-robin write arbiter and occupancy tracker in front of a single FIFO.
// Define FIFO_ARB_STATS_EN to build the full-FIFO stall counter behind stall_cnt.
module fifo_arb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [6:0]                 len,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       rd_req,
  output logic                       rd_gnt,
  output logic                       fifo_en,
  output logic                       fifo_wr,
  output logic                       fifo_rd,
  output logic [DATA_WIDTH-1:0]      fifo_wdata,
  output logic [6:0]                 fifo_len,
  output logic                       fifo_clr,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic [7:0]                 count,
  output logic [15:0]                stall_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [7:0]      count_q, count_d;
  logic [7:0]      depth_q, depth_d;
  logic [PW-1:0]   rr_q, rr_d;

  logic [NREQ-1:0] gnt_c;
  logic [NREQ-1:0] mask_hi;
  logic [NREQ-1:0] pick;
  logic            rd_c;
  logic            wr_c;
  logic            wr_ok;
  logic [DATA_WIDTH-1:0] wdata_c;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest set bit.
  always_comb begin
    rd_c    = !reset && (state_q != IDLE) && rd_req && (count_q != '0);
    wr_ok   = !reset && (state_q == RUN) && ((count_q < depth_q) || rd_c);
    mask_hi = '1;
    mask_hi = mask_hi << rr_q;
    pick    = ((req & mask_hi) != '0) ? (req & mask_hi) : req;
    gnt_c   = wr_ok ? (pick & ((~pick) + NREQ'(1))) : '0;
    wr_c    = (gnt_c != '0);
  end

  always_comb begin
    rr_d    = rr_q;
    wdata_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (((gnt_c >> i) & NREQ'(1)) != '0) begin
        rr_d    = (i == NREQ - 1) ? '0 : PW'(i + 1);
        wdata_c = DATA_WIDTH'(req_data >> (i * DATA_WIDTH));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    count_d = count_q;
    case ({wr_c, rd_c})
      2'b10:   count_d = count_q + 8'd1;
      2'b01:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: begin
        if (start) begin
          depth_d = (len == 7'd0) ? 8'd128 : {1'b0, len};
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      depth_q <= 8'd128;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      depth_q <= depth_d;
      rr_q    <= rr_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == RUN && (req != '0) && !wr_c && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign gnt        = gnt_c;
  assign rd_gnt     = rd_c;
  assign fifo_wr    = wr_c;
  assign fifo_rd    = rd_c;
  assign fifo_en    = wr_c | rd_c;
  assign fifo_wdata = wdata_c;
  assign fifo_len   = depth_q[6:0];
  assign fifo_clr   = reset | ((state_q == IDLE) & start);
  assign busy       = (state_q != IDLE);
  assign full       = (count_q == depth_q);
  assign empty      = (count_q == '0);
  assign count      = count_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Self-checking bench for fifo_arb_ctrl: directed scenarios plus randomized traffic
// checked against a queue-free occupancy/round-robin reference model.
module tb_fifo_arb_ctrl;

`ifdef FIFO_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stop, rd_req;
  logic [6:0]  len;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rd_gnt, fifo_en, fifo_wr, fifo_rd, fifo_clr, busy, full, empty;
  logic [7:0]  fifo_wdata, count;
  logic [6:0]  fifo_len;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit         m_busy, m_drain;
  int         m_count, m_depth, m_ptr, m_stall;
  logic [3:0] exp_gnt;
  logic       exp_rd, exp_clr;
  logic [7:0] exp_wdata;

  fifo_arb_ctrl #(.DATA_WIDTH(8), .NREQ(4)) dut (
    .clk(clk), .reset(rst), .start(start), .stop(stop), .len(len),
    .req(req), .req_data(req_data), .gnt(gnt), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .fifo_en(fifo_en), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_wdata(fifo_wdata),
    .fifo_len(fifo_len), .fifo_clr(fifo_clr), .busy(busy), .full(full), .empty(empty),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    exp_gnt   = 4'b0;
    exp_rd    = 1'b0;
    exp_wdata = 8'h00;
    exp_clr   = rst;
    if (!rst) begin
      if (!m_busy) begin
        exp_clr = start;
      end else begin
        exp_rd = rd_req && (m_count > 0);
        if (!m_drain && (m_count < m_depth || exp_rd)) begin
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (exp_gnt == 4'b0 && req[idx]) begin
              exp_gnt   = 4'(1 << idx);
              exp_wdata = 8'(req_data >> (idx * 8));
            end
          end
        end
      end
    end
  endfunction

  function automatic void model_commit();
    if (rst) begin
      m_busy = 0; m_drain = 0; m_count = 0; m_depth = 128; m_ptr = 0; m_stall = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_depth = (len == 0) ? 128 : int'(len);
        m_count = 0; m_busy = 1; m_drain = 0;
        m_stall = 0;
      end
    end else begin
      bit was_drain;
      was_drain = m_drain;
      if (STATS && !was_drain && req != 0 && exp_gnt == 0 && m_stall < 65535) m_stall++;
      for (int i = 0; i < 4; i++) if (exp_gnt == 4'(1 << i)) m_ptr = (i + 1) % 4;
      m_count = m_count + ((exp_gnt != 0) ? 1 : 0) - (exp_rd ? 1 : 0);
      if (was_drain) begin
        if (m_count == 0) begin m_busy = 0; m_drain = 0; end
      end else if (stop) begin
        m_drain = 1;
      end
    end
  endfunction

  task automatic drive(input logic s, input logic st, input logic [6:0] l,
                       input logic [3:0] r, input logic rd);
    start = s; stop = st; len = l; req = r; rd_req = rd;
    req_data = $urandom;
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 7'd0, 4'b0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 7'd5, 4'b1111, 1);
    n_checks++;
    if (fifo_clr !== 1'b1 || gnt !== 4'b0 || rd_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: clr=%b gnt=%b rd_gnt=%b want clr=1 gnt=0000 rd_gnt=0", fifo_clr, gnt, rd_gnt);
    end
    step();
    rst = 1'b0;
    drive(0, 0, 7'd0, 4'b0, 0);
    n_checks++;
    if (busy !== 1'b0 || count !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
        fifo_len !== 7'd0 || stall_cnt !== 16'd0 || fifo_en !== 1'b0 || fifo_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b count=%0d empty=%b full=%b len=%0d stall=%0d en=%b clr=%b want 0,0,1,0,0,0,0,0",
               busy, count, empty, full, fifo_len, stall_cnt, fifo_en, fifo_clr);
    end
  endtask

  task automatic test_fill_128();
    int grants;
    do_reset();
    drive(1, 0, 7'd0, 4'b0, 0);
    n_checks++;
    if (fifo_clr !== 1'b1 || gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL start_clr: clr=%b gnt=%b want clr=1 gnt=0000", fifo_clr, gnt);
    end
    step();
    grants = 0;
    for (int k = 0; k < 130; k++) begin
      logic [3:0] want;
      logic [7:0] want_d;
      drive(0, 0, 7'd0, 4'b1111, 0);
      want   = (k < 128) ? 4'(1 << (k % 4)) : 4'b0;
      want_d = (k < 128) ? 8'(req_data >> ((k % 4) * 8)) : 8'h00;
      n_checks++;
      if (gnt !== want || fifo_wdata !== want_d || fifo_wr !== (want != 0)) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: gnt=%b wdata=%h wr=%b want gnt=%b wdata=%h", k, gnt, fifo_wdata, fifo_wr, want, want_d);
      end
      if (gnt != 0) grants++;
      step();
    end
    n_checks++;
    if (grants != 128 || full !== 1'b1 || count !== 8'd128 || fifo_len !== 7'd0) begin
      n_fail++;
      $display("FAIL fill_end: grants=%0d full=%b count=%0d len=%0d want 128,1,128,0", grants, full, count, fifo_len);
    end
  endtask

  task automatic test_plateau();
    do_reset();
    drive(1, 0, 7'd4, 4'b0, 0);
    step();
    for (int c = 1; c <= 10; c++) begin
      logic [3:0] want;
      drive(0, 0, 7'd4, 4'b0101, c >= 3);
      want = (c % 2 == 1) ? 4'b0001 : 4'b0100;
      n_checks++;
      if (gnt !== want || rd_gnt !== (c >= 3)) begin
        n_fail++;
        $display("FAIL plateau_gnt[%0d]: gnt=%b rd_gnt=%b want gnt=%b rd_gnt=%b", c, gnt, rd_gnt, want, c >= 3);
      end
      step();
      n_checks++;
      if (count !== 8'((c < 2) ? c : 2) || count > 8'd4) begin
        n_fail++;
        $display("FAIL plateau_count[%0d]: count=%0d want %0d", c, count, (c < 2) ? c : 2);
      end
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    drive(1, 0, 7'd8, 4'b0, 0);
    step();
    drive(0, 0, 7'd8, 4'b0010, 1);
    n_checks++;
    if (gnt !== 4'b0010 || rd_gnt !== 1'b0 || fifo_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_rw: gnt=%b rd_gnt=%b fifo_rd=%b want 0010,0,0", gnt, rd_gnt, fifo_rd);
    end
    step();
    drive(0, 0, 7'd8, 4'b0010, 1);
    n_checks++;
    if (count !== 8'd1 || rd_gnt !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_rw_next: count=%0d rd_gnt=%b empty=%b want 1,1,0", count, rd_gnt, empty);
    end
    step();
  endtask

  task automatic test_drain();
    int pulses;
    do_reset();
    drive(1, 0, 7'd8, 4'b0, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 7'd8, 4'b0001, 0);
      step();
    end
    drive(0, 1, 7'd8, 4'b0000, 1);
    pulses = rd_gnt ? 1 : 0;
    n_checks++;
    if (gnt !== 4'b0 || rd_gnt !== 1'b1 || count !== 8'd3) begin
      n_fail++;
      $display("FAIL drain_stop: gnt=%b rd_gnt=%b count=%0d want 0000,1,3", gnt, rd_gnt, count);
    end
    step();
    for (int c = 0; c < 6 && busy; c++) begin
      drive(1, 0, 7'd8, 4'b1111, 1);
      n_checks++;
      if (gnt !== 4'b0) begin
        n_fail++;
        $display("FAIL drain_nognt[%0d]: gnt=%b want 0000", c, gnt);
      end
      if (rd_gnt) pulses++;
      step();
      n_checks++;
      if (busy !== (count != 0)) begin
        n_fail++;
        $display("FAIL drain_busy[%0d]: busy=%b count=%0d want busy=%b", c, busy, count, count != 0);
      end
    end
    n_checks++;
    if (pulses != 3 || busy !== 1'b0 || count !== 8'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: pulses=%0d busy=%b count=%0d empty=%b want 3,0,0,1", pulses, busy, count, empty);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 0, 7'd2, 4'b0, 0);
    step();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 7'd2, 4'b0001, 0);
      step();
    end
    n_checks++;
    if (stall_cnt !== (STATS ? 16'd8 : 16'd0) || full !== 1'b1 || count !== 8'd2) begin
      n_fail++;
      $display("FAIL stall_count: stall=%0d full=%b count=%0d want %0d,1,2", stall_cnt, full, count, STATS ? 8 : 0);
    end
    drive(0, 1, 7'd2, 4'b0, 1);
    step();
    drive(0, 0, 7'd2, 4'b0, 1);
    step();
    drive(1, 0, 7'd3, 4'b0, 0);
    step();
    n_checks++;
    if (stall_cnt !== 16'd0 || busy !== 1'b1 || fifo_len !== 7'd3) begin
      n_fail++;
      $display("FAIL stall_clear: stall=%0d busy=%b len=%0d want 0,1,3", stall_cnt, busy, fifo_len);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    drive(1, 0, 7'd8, 4'b0, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 7'd8, 4'b0001, 0);
      step();
    end
    rst = 1'b1;
    drive(0, 0, 7'd8, 4'b0001, 1);
    n_checks++;
    if (count !== 8'd5 || gnt !== 4'b0 || fifo_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_assert: count=%0d gnt=%b clr=%b want 5,0000,1", count, gnt, fifo_clr);
    end
    step();
    drive(0, 0, 7'd8, 4'b0001, 1);
    n_checks++;
    if (count !== 8'd0 || gnt !== 4'b0 || fifo_clr !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_after: count=%0d gnt=%b clr=%b busy=%b want 0,0000,1,0", count, gnt, fifo_clr, busy);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [6:0] l;
      rst = ($urandom_range(0, 199) == 0);
      l   = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
      drive($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0, l,
            4'($urandom), $urandom_range(0, 2) != 0);
      n_checks++;
      if (gnt !== exp_gnt || rd_gnt !== exp_rd || fifo_wr !== (exp_gnt != 0) ||
          fifo_rd !== exp_rd || fifo_en !== ((exp_gnt != 0) || exp_rd) ||
          fifo_wdata !== exp_wdata || fifo_clr !== exp_clr) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: gnt=%b rd=%b wd=%h clr=%b en=%b want gnt=%b rd=%b wd=%h clr=%b",
                 c, gnt, rd_gnt, fifo_wdata, fifo_clr, fifo_en, exp_gnt, exp_rd, exp_wdata, exp_clr);
      end
      step();
      n_checks++;
      if (count !== 8'(m_count) || busy !== m_busy || full !== (m_count == m_depth) ||
          empty !== (m_count == 0) || fifo_len !== 7'(m_depth % 128) || stall_cnt !== 16'(m_stall)) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: count=%0d busy=%b full=%b empty=%b len=%0d stall=%0d want %0d,%b,%b,%b,%0d,%0d",
                 c, count, busy, full, empty, fifo_len, stall_cnt, m_count, m_busy,
                 m_count == m_depth, m_count == 0, m_depth % 128, m_stall);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; len = 0; req = 0; rd_req = 0; req_data = 0;
    m_busy = 0; m_drain = 0; m_count = 0; m_depth = 128; m_ptr = 0; m_stall = 0;
    @(negedge clk);
    test_reset();
    test_fill_128();
    test_plateau();
    test_empty_rw();
    test_drain();
    test_stall();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of one FIFO word.
REQ-002 The block SHALL have parameter NREQ, default 4, the number of write requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, which latches the length and begins a run.
REQ-006 The block SHALL have port stop, input, 1, which ends write acceptance and drains the FIFO.
REQ-007 The block SHALL have port len, input, 7, the FIFO depth for the run; 0 means 128.
REQ-008 The block SHALL have port req, input, NREQ, the per-requester write requests.
REQ-009 The block SHALL have port req_data, input, NREQ*DATA_WIDTH, where requester i's word occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port gnt, output, NREQ, a one-hot write grant, meaning the word is accepted this cycle.
REQ-011 The block SHALL have port rd_req, input, 1, the consumer's read request.
REQ-012 The block SHALL have port rd_gnt, output, 1, meaning a read is issued to the FIFO this cycle.
REQ-013 The block SHALL have FIFO-side outputs fifo_en (1), fifo_wr (1), fifo_rd (1), fifo_wdata (DATA_WIDTH), fifo_len (7) and fifo_clr (1), with fifo_clr driving the FIFO's reset.
REQ-014 The block SHALL have status outputs busy (1), full (1), empty (1), count (8) and stall_cnt (16).

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-016 In IDLE, start SHALL latch len into a depth register (0 becomes 128), clear count, pulse fifo_clr for exactly one cycle, and enter RUN on the next edge.
REQ-017 In IDLE, no gnt or rd_gnt SHALL be asserted.
REQ-018 In RUN, at most one gnt bit SHALL assert per cycle, and only when count < depth or a read is granted in the same cycle.
REQ-019 Arbitration SHALL be round-robin: search starts at the requester after the last granted one (initially 0); the pointer updates only on a grant.
REQ-020 rd_gnt SHALL equal rd_req AND (count > 0) in RUN and DRAIN; a same-cycle write never satisfies a read while empty.
REQ-021 fifo_wr, fifo_wdata (the mux of the granted requester) and fifo_rd SHALL be combinational from gnt/rd_gnt; fifo_en SHALL be their OR; fifo_len SHALL be the depth register's low 7 bits.
REQ-022 count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-023 full SHALL be (count == depth) and empty SHALL be (count == 0), both registered-state based.
REQ-024 In RUN, stop SHALL move the FSM to DRAIN; a write granted in the stop cycle is still accepted.
REQ-025 In DRAIN, no gnt SHALL be issued; the FSM SHALL go to IDLE on the edge where count becomes 0, or immediately if count is already 0.
REQ-026 start SHALL be ignored outside IDLE; if start and stop are both asserted in IDLE, start SHALL win.
REQ-027 busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE; count, gnt, rd_gnt, fifo_en, fifo_wr and fifo_rd SHALL be 0; the RR pointer SHALL be 0; depth SHALL be 128; stall_cnt SHALL be 0.
REQ-029 fifo_clr SHALL be 1 during reset so the FIFO is cleared with it.
REQ-030 Reset mid-run SHALL abandon the run with no further grants from the next cycle.
REQ-031 empty SHALL be 1 and full SHALL be 0 out of reset.

Configuration
REQ-032 With FIFO_ARB_STATS_EN defined, stall_cnt SHALL increment (saturating at 16'hFFFF) each RUN cycle in which any req is high and no gnt is issued because the FIFO is full, and SHALL clear on start.
REQ-033 Without FIFO_ARB_STATS_EN, stall_cnt SHALL be the constant 0 and no counter logic SHALL be present.

Verification
REQ-034 reset, then start with len=0 and req=4'b1111 held for 130 cycles -> grants in the order 0,1,2,3,0,... for exactly 128 grants, then full=1, count=128.
REQ-035 len=4, req=4'b0101 held, rd_req=1 from cycle 3 -> gnt alternates bits 0 and 2; count plateaus with a simultaneous read/write each cycle; count never exceeds 4.
REQ-036 Empty FIFO, req[1]=1 and rd_req=1 in the same cycle -> gnt[1]=1, rd_gnt=0, count=1; the next cycle rd_gnt=1.
REQ-037 count=3, stop asserted, rd_req=1 -> no gnt, three rd_gnt pulses, busy falls on the edge count reaches 0, FSM in IDLE.
REQ-038 With FIFO_ARB_STATS_EN, len=2, req=1 and no reads for 10 cycles -> stall_cnt=8; without the macro -> stall_cnt=0.
REQ-039 Reset asserted in RUN with count=5 -> next cycle count=0, gnt=0, fifo_clr=1, busy=0.
